instr_fetch_unit: RTL and testbench

- Sequential fetch stage directly upstream of the instruction decoder/controller in the multicycle RISC core.
- Owns the PC and fetches one 32-bit word from instruction memory over a req/rvalid handshake.
- Latches the word into an instruction register and presents opcode/func to decode with a valid/ready handshake.
- Waits for the downstream branch resolution (jump/branch/bl/br outcome) before computing the next PC.

---
 rtl/instr_fetch_unit_pkg.sv | 9 +
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encodings and instruction field constants for the fetch stage
package instr_fetch_unit_pkg;
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_ISSUE, S_EXEC, S_HALT} state_t;
  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, decode and branch-resolution signals of the fetch stage
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] instr;
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] link_pc;
  logic              resolve_valid;
  logic              resolve_taken;
  logic [ADDR_W-1:0] resolve_target;
  logic              halted;
  logic [15:0]       retired_cnt;
  modport master (
    output imem_req, imem_addr, ir_valid, instr, opcode, func, pc_out, link_pc, halted, retired_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, ir_ready, resolve_valid, resolve_taken, resolve_target
  );
  modport slave (
    input  imem_req, imem_addr, ir_valid, instr, opcode, func, pc_out, link_pc, halted, retired_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, ir_ready, resolve_valid, resolve_taken, resolve_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch stage owning the PC, instruction register and retire counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [15:0]       ret_q, ret_d;
  logic              req_q, req_d, irv_q, irv_d, halted_q, halted_d;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    ret_d    = ret_q;
    unique case (state_q)
      S_REQ:   if (req_q && bus.imem_gnt) state_d = S_WAIT;
      S_WAIT:  if (bus.imem_rvalid) begin
        instr_d  = bus.imem_rdata;
        pc_out_d = pc_q;
        state_d  = S_ISSUE;
      end
      S_ISSUE: if (irv_q && bus.ir_ready)
        state_d = (instr_q[OPC_MSB:OPC_LSB] == OPC_HALT) ? S_HALT : S_EXEC;
      S_EXEC:  if (bus.resolve_valid) begin
        pc_d    = bus.resolve_taken ? bus.resolve_target : pc_q + 1'b1;
        ret_d   = ret_q + 1'b1;
        state_d = S_REQ;
      end
      default: ;
    endcase
    // req stays low for the first cycle out of reset even though the FSM already sits in S_REQ
    req_d    = state_d == S_REQ;
    irv_d    = state_d == S_ISSUE;
    halted_d = state_d == S_HALT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= '0;
      ret_q    <= '0;
      req_q    <= 1'b0;
      irv_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      ret_q    <= ret_d;
      req_q    <= req_d;
      irv_q    <= irv_d;
      halted_q <= halted_d;
    end
  end
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.ir_valid    = irv_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign bus.func        = instr_q[FUNC_MSB:FUNC_LSB];
  assign bus.pc_out      = pc_out_q;
  assign bus.link_pc     = pc_out_q + 1'b1;
  assign bus.halted      = halted_q;
  assign bus.retired_cnt = ret_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch/resolve sequence with a scoreboard of expected IR contents
module tb_instr_fetch_unit;
  typedef struct {
    logic [31:0] ins;
    logic [9:0]  pc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [9:0]  pc_m = '0;
  logic [15:0] ret_m = '0;
  instr_fetch_unit_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  instr_fetch_unit #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_fetch(input logic [31:0] data, input int gnt_dly, input int rdy_dly);
    exp_t e;
    logic [9:0] lp;
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", {31'd0, bus.imem_req}, 32'd1);
    chk("imem_addr", {22'd0, bus.imem_addr}, {22'd0, pc_m});
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_hold", {22'd0, bus.imem_addr}, {22'd0, pc_m});
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
    sb.push_back('{ins: data, pc: pc_m});
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hx;
    n = 0;
    while (!bus.ir_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("irv_timeout", {31'd0, bus.ir_valid}, 32'd1);
    e  = sb.pop_front();
    lp = e.pc + 10'd1;
    chk("instr", bus.instr, e.ins);
    chk("opcode", {26'd0, bus.opcode}, {26'd0, e.ins[31:26]});
    chk("func", {26'd0, bus.func}, {26'd0, e.ins[5:0]});
    chk("pc_out", {22'd0, bus.pc_out}, {22'd0, e.pc});
    chk("link_pc", {22'd0, bus.link_pc}, {22'd0, lp});
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("irv_hold", {31'd0, bus.ir_valid}, 32'd1);
      chk("instr_hold", bus.instr, e.ins);
    end
    bus.ir_ready = 1'b1;
    @(negedge clk);
    bus.ir_ready = 1'b0;
    chk("irv_drop", {31'd0, bus.ir_valid}, 32'd0);
  endtask
  task automatic do_resolve(input logic taken, input logic [9:0] target);
    bus.resolve_valid  = 1'b1;
    bus.resolve_taken  = taken;
    bus.resolve_target = target;
    @(negedge clk);
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    pc_m  = taken ? target : pc_m + 10'd1;
    ret_m = ret_m + 16'd1;
    chk("retired_cnt", {16'd0, bus.retired_cnt}, {16'd0, ret_m});
    chk("next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("next_addr", {22'd0, bus.imem_addr}, {22'd0, pc_m});
  endtask
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.ir_ready = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.resolve_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_irv", {31'd0, bus.ir_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_retired", {16'd0, bus.retired_cnt}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", {22'd0, bus.imem_addr}, 32'd0);
    chk("rel_irv", {31'd0, bus.ir_valid}, 32'd0);
    do_fetch(32'h0000_0001, 0, 0);
    do_resolve(1'b0, 10'h000);
    do_fetch(32'h0800_0010, 0, 0);
    do_resolve(1'b1, 10'h02A);
    do_fetch(32'h1234_5678, 3, 4);
    do_resolve(1'b1, 10'h3FF);
    do_fetch(32'hABCD_0001, 0, 0);
    do_resolve(1'b0, 10'h155);
    do_fetch(32'hFC00_0000, 0, 0);
    chk("halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b1;
    bus.resolve_target = 10'h100;
    repeat (2) @(negedge clk);
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    chk("halt_retired", {16'd0, bus.retired_cnt}, {16'd0, ret_m});
    chk("halt_stay", {31'd0, bus.halted}, 32'd1);
    chk("halt_irv", {31'd0, bus.ir_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_halted", {31'd0, bus.halted}, 32'd0);
    chk("arst_retired", {16'd0, bus.retired_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pc_m = 10'd0;
    ret_m = 16'd0;
    @(negedge clk);
    chk("re_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("wait_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("late_irv", {31'd0, bus.ir_valid}, 32'd0);
    chk("late_instr", bus.instr, 32'd0);
    chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", {22'd0, bus.imem_addr}, 32'd0);
    do_fetch(32'h0400_0003, 0, 0);
    do_resolve(1'b0, 10'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
